fir_sequencer: RTL and testbench
================================

FIR_SEQUENCER -- requirements
Module: fir_sequencer

Interface
REQ-001 Parameter NTAPS, default 10: number of filter taps; legal range 2..2^SEL_W.
REQ-002 Parameter SEL_W, default 4: width of the tap-select bus.
REQ-003 clk  input  1: single clock; all state changes on the rising edge.
REQ-004 rst  input  1: reset, asynchronous, active-low; 0 resets the block immediately.
REQ-005 sample_vld  input  1: one-cycle pulse; a new input sample x is present at the delay-line head input.
REQ-006 y_ack  input  1: the consumer has taken the filtered output.
REQ-007 clr_ovr  input  1: clears the overrun flag.
REQ-008 leer  output  1: capture the new sample into the delay-line head.
REQ-009 rst_acum  output  1: clear the accumulator.
REQ-010 en_acum  output  1: accumulate the product of coefficient[sel] and tap[sel].
REQ-011 sel  output  SEL_W: tap/coefficient index for the multiplier mux.
REQ-012 leer_y  output  1: load the accumulator into the output register.
REQ-013 desp  output  1: shift the delay line by one position.
REQ-014 y_valid  output  1: the output register holds an unacknowledged result.
REQ-015 busy  output  1: a sample is being processed.
REQ-016 overrun  output  1: sticky flag; a sample was dropped.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, CLR, MAC, STORE and SHIFT; the strobes (leer, rst_acum, en_acum, leer_y, desp), sel and busy SHALL be decoded from state and tap count only.
REQ-018 In IDLE, sample_vld=1 with (y_valid=0 or y_ack=1) SHALL accept the sample, and the FSM SHALL go to LOAD on the next cycle.
REQ-019 LOAD: leer=1 for exactly one cycle, then CLR.
REQ-020 CLR: rst_acum=1, sel=0 for exactly one cycle, then MAC.
REQ-021 MAC: en_acum=1 for exactly NTAPS cycles; sel = 0,1,...,NTAPS-1, incrementing by one per cycle; after sel=NTAPS-1 the FSM goes to STORE.
REQ-022 STORE: leer_y=1 for exactly one cycle, then SHIFT.
REQ-023 SHIFT: desp=1 for exactly one cycle, then IDLE.
REQ-024 Outside MAC, sel SHALL be 0; sel SHALL never exceed NTAPS-1.
REQ-025 busy SHALL be 1 in every state except IDLE.
REQ-026 Latency: for a sample accepted at cycle T, STORE SHALL occur at T+3+NTAPS, y_valid SHALL rise at T+4+NTAPS, and the FSM SHALL return to IDLE at T+5+NTAPS.
REQ-027 y_valid SHALL be set on the edge that ends STORE, and cleared on the edge where y_ack=1 and y_valid=1; y_ack while y_valid=0 SHALL be ignored.
REQ-028 sample_vld while busy=1, or in IDLE with y_valid=1 and y_ack=0, SHALL drop the sample: no strobe is generated and overrun is set.
REQ-029 overrun SHALL be cleared by clr_ovr=1; if a set condition and clr_ovr coincide, overrun SHALL be 1.
REQ-030 At most one strobe among leer, rst_acum, en_acum, leer_y and desp SHALL be 1 in any cycle.
REQ-031 Back-to-back operation: a sample accepted in the first IDLE cycle after SHIFT SHALL start a new sequence with no extra idle cycles.

Reset
REQ-032 rst=0 SHALL asynchronously force state to IDLE, the tap count to 0, and all outputs to 0 (sel=0, y_valid=0, overrun=0, busy=0).
REQ-033 Reset asserted mid-sequence SHALL abort the sequence; after rst returns to 1, the FSM SHALL wait in IDLE for the next sample_vld.

Verification (NTAPS=10)
REQ-034 Single sample: sample_vld at T -> leer@T+1, rst_acum@T+2, en_acum T+3..T+12 with sel 0..9, leer_y@T+13, desp@T+14, y_valid=1 from T+14, busy=0 at T+15.
REQ-035 Overrun while busy: sample_vld at T, then again at T+5 -> second sample produces no strobes, overrun=1 from T+6, first sequence unchanged; clr_ovr at T+20 -> overrun=0 at T+21.
REQ-036 Output not acknowledged: after REQ-034, with y_ack held 0, sample_vld at T+16 -> dropped, overrun=1; y_ack=1 together with sample_vld at T+18 -> accepted, y_valid=0 at T+19, leer@T+19.
REQ-037 Reset mid-MAC: rst=0 while sel=4 -> same instant: all outputs 0, sel=0; after release, no strobes until the next sample_vld.
REQ-038 Continuous stream: sample_vld every 15 cycles with y_ack pulsed each time y_valid=1 -> no overrun, exactly 10 en_acum cycles per sample, strobe exclusivity holds throughout.

Source files
------------

// File: rtl/fir_sequencer.sv
// Control sequencer for a multiply-accumulate FIR datapath.
// Each accepted sample walks LOAD -> CLR -> MAC (NTAPS cycles) -> STORE -> SHIFT
// and returns to IDLE. Strobes, sel and busy are decoded from state and tap count
// only, so an asynchronous reset clears them immediately.
module fir_sequencer #(
    parameter int NTAPS = 10,
    parameter int SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_vld,
    input  logic             y_ack,
    input  logic             clr_ovr,
    output logic             leer,
    output logic             rst_acum,
    output logic             en_acum,
    output logic [SEL_W-1:0] sel,
    output logic             leer_y,
    output logic             desp,
    output logic             y_valid,
    output logic             busy,
    output logic             overrun
);

    typedef enum logic [2:0] {IDLE, LOAD, CLR, MAC, STORE, SHIFT} state_t;

    localparam logic [SEL_W-1:0] LAST_TAP = SEL_W'(NTAPS - 1);

    state_t           state, state_nxt;
    logic [SEL_W-1:0] cnt, cnt_nxt;
    logic             accept, drop;

    // A sample is taken only in IDLE and only when the previous result is gone
    // (or being acknowledged this very cycle); anything else is dropped.
    assign accept = (state == IDLE) && sample_vld && (!y_valid || y_ack);
    assign drop   = sample_vld && !accept;

    // State and tap-count registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic and strobe decode.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        leer      = 1'b0;
        rst_acum  = 1'b0;
        en_acum   = 1'b0;
        sel       = '0;
        leer_y    = 1'b0;
        desp      = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy    = 1'b0;
                cnt_nxt = '0;
                if (accept) state_nxt = LOAD;
            end
            LOAD: begin
                leer      = 1'b1;
                state_nxt = CLR;
            end
            CLR: begin
                rst_acum  = 1'b1;
                cnt_nxt   = '0;
                state_nxt = MAC;
            end
            MAC: begin
                en_acum = 1'b1;
                sel     = cnt;
                if (cnt == LAST_TAP) begin
                    cnt_nxt   = '0;
                    state_nxt = STORE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            STORE: begin
                leer_y    = 1'b1;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                desp      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Output-valid flag: a fresh result from STORE wins over a same-cycle ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                 y_valid <= 1'b0;
        else if (state == STORE)  y_valid <= 1'b1;
        else if (y_ack && y_valid) y_valid <= 1'b0;
    end

    // Sticky overrun flag: a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         overrun <= 1'b0;
        else if (drop)    overrun <= 1'b1;
        else if (clr_ovr) overrun <= 1'b0;
    end

endmodule

// File: tb/tb_fir_sequencer.sv
// Directed bench for fir_sequencer with NTAPS=10: single sample, unacked output,
// overrun while busy, reset mid-MAC and a continuous stream.
module tb_fir_sequencer;

    localparam int NTAPS = 10;
    localparam int SEL_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             sample_vld = 1'b0;
    logic             y_ack = 1'b0;
    logic             clr_ovr = 1'b0;
    logic             leer, rst_acum, en_acum, leer_y, desp, y_valid, busy, overrun;
    logic [SEL_W-1:0] sel;

    int n_tests = 0;
    int n_fail  = 0;
    int en_cnt  = 0;

    fir_sequencer #(.NTAPS(NTAPS), .SEL_W(SEL_W)) dut (
        .clk(clk), .rst(rst), .sample_vld(sample_vld), .y_ack(y_ack), .clr_ovr(clr_ovr),
        .leer(leer), .rst_acum(rst_acum), .en_acum(en_acum), .sel(sel),
        .leer_y(leer_y), .desp(desp), .y_valid(y_valid), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected strobes k cycles after the accept cycle (k=1 is LOAD).
    task automatic chk_step(input int k);
        logic e_leer, e_rst, e_en, e_ly, e_desp, e_busy;
        logic [SEL_W-1:0] e_sel;
        e_leer = (k == 1);
        e_rst  = (k == 2);
        e_en   = (k >= 3) && (k <= 12);
        e_ly   = (k == 13);
        e_desp = (k == 14);
        e_busy = (k >= 1) && (k <= 14);
        e_sel  = e_en ? SEL_W'(k - 3) : '0;
        chk($sformatf("strobes_k%0d", k), {26'd0, leer, rst_acum, en_acum, leer_y, desp, busy},
            {26'd0, e_leer, e_rst, e_en, e_ly, e_desp, e_busy});
        chk($sformatf("sel_k%0d", k), 32'(sel), 32'(e_sel));
    endtask

    // Continuous invariants: one strobe at most, sel in range and zero outside MAC.
    always @(negedge clk) begin
        if (rst) begin
            chk("excl", 32'($countones({leer, rst_acum, en_acum, leer_y, desp}) <= 1), 32'd1);
            chk("sel_rng", 32'((sel <= SEL_W'(NTAPS - 1)) && (en_acum || sel == '0)), 32'd1);
            if (en_acum) en_cnt++;
        end
    end

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_outs", {23'd0, leer, rst_acum, en_acum, leer_y, desp, y_valid, busy, overrun, 1'b0},
            32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        rst = 1'b1;
        tick();

        // Single sample, then unacked-output drop, then accept with ack
        sample_vld = 1'b1;
        tick();
        sample_vld = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            chk_step(k);
            chk($sformatf("yv_k%0d", k), 32'(y_valid), 32'(k >= 14));
            if (k < 15) tick();
        end
        tick();                       // T+16
        sample_vld = 1'b1;
        tick();                       // T+17
        sample_vld = 1'b0;
        chk("unack_drop_ovr", 32'(overrun), 32'd1);
        chk("unack_drop_busy", {30'd0, busy, leer}, 32'd0);
        chk("unack_yv_held", 32'(y_valid), 32'd1);
        tick();                       // T+18
        sample_vld = 1'b1;
        y_ack      = 1'b1;
        tick();                       // T+19
        sample_vld = 1'b0;
        y_ack      = 1'b0;
        chk("ack_yv_clr", 32'(y_valid), 32'd0);
        chk_step(1);
        for (int k = 2; k <= 15; k++) begin
            tick();
            chk_step(k);
        end
        chk("seq2_yv", 32'(y_valid), 32'd1);
        y_ack = 1'b1;
        tick();
        y_ack = 1'b0;
        chk("ack_clr", 32'(y_valid), 32'd0);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        chk("clr_ovr", 32'(overrun), 32'd0);

        // Overrun while busy; drop+clear coincide keeps flag; early y_ack ignored
        sample_vld = 1'b1;
        tick();
        for (int k = 1; k <= 21; k++) begin
            if (k <= 15) chk_step(k);
            else         chk($sformatf("ovr_idle_k%0d", k), 32'(busy), 32'd0);
            chk($sformatf("ovr_k%0d", k), 32'(overrun), 32'((k >= 6) && (k <= 20)));
            chk($sformatf("ovr_yv_k%0d", k), 32'(y_valid), 32'(k == 14));
            sample_vld = (k == 5) || (k == 8);
            clr_ovr    = (k == 8) || (k == 20);
            y_ack      = (k == 2) || (k == 14);
            tick();
        end
        sample_vld = 1'b0;
        clr_ovr    = 1'b0;
        y_ack      = 1'b0;

        // Reset mid-MAC
        sample_vld = 1'b1;
        tick();
        sample_vld = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            if (k == 2) sample_vld = 1'b1;
            else        sample_vld = 1'b0;
            if (k < 7) tick();
        end
        sample_vld = 1'b0;
        chk("pre_rst_sel", 32'(sel), 32'd4);
        chk("pre_rst_ovr", 32'(overrun), 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("midrst_outs", {23'd0, leer, rst_acum, en_acum, leer_y, desp, y_valid, busy, overrun, 1'b0},
            32'd0);
        chk("midrst_sel", 32'(sel), 32'd0);
        tick();
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("post_rst_c%0d", c), {26'd0, leer, rst_acum, en_acum, leer_y, desp, busy}, 32'd0);
        end
        sample_vld = 1'b1;
        tick();
        sample_vld = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            chk_step(k);
            if (k < 15) tick();
        end
        y_ack = 1'b1;
        tick();
        y_ack = 1'b0;

        // Continuous stream, one sample every 15 cycles
        en_cnt = 0;
        for (int c = 0; c < 60; c++) begin
            sample_vld = (c % 15 == 0);
            y_ack      = y_valid;
            tick();
        end
        sample_vld = 1'b0;
        y_ack      = 1'b0;
        tick();
        chk("stream_ovr", 32'(overrun), 32'd0);
        chk("stream_en_cnt", 32'(en_cnt), 32'd40);
        chk("stream_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
